// File: rtl/posit_pkg.sv
// Shared posit definitions: rounding modes, width helper and special-value constants.
package posit_pkg;

    typedef enum logic {
        RND_RNE = 1'b0,
        RND_RTZ = 1'b1
    } rnd_mode_e;

    typedef enum logic [1:0] {
        PC_MAXPOS,
        PC_MINPOS,
        PC_NAR
    } posit_const_e;

    localparam int MAX_N = 64;

    function automatic int scale_width(input int n, input int es);
        return $clog2(n) + es + 2;
    endfunction

    // Constants are returned at MAX_N width; callers cast down to their own N.
    function automatic logic [MAX_N-1:0] posit_const(input int n, input posit_const_e sel);
        logic [MAX_N-1:0] c;
        c = '0;
        case (sel)
            PC_MAXPOS: c = (MAX_N'(1) << (n - 1)) - MAX_N'(1);
            PC_MINPOS: c = MAX_N'(1);
            PC_NAR:    c = MAX_N'(1) << (n - 1);
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/posit_regime_enc.sv
// Combinational posit encoder: scale decode with saturation detect (first stage) and
// regime/exponent/fraction body assembly with guard and sticky extraction (second stage).
module posit_regime_enc
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int SW = scale_width(N, ES)
) (
    input  logic signed [SW-1:0]                  scale,
    output logic signed [SW-ES-1:0]               k,
    output logic        [((ES > 0) ? ES : 1)-1:0] e,
    output logic                                  sat_hi,
    output logic                                  sat_lo,
    input  logic signed [SW-ES-1:0]               k_q,
    input  logic        [((ES > 0) ? ES : 1)-1:0] e_q,
    input  logic        [N-1:0]                   frac_q,
    input  logic                                  sticky_q,
    input  logic                                  sat_hi_q,
    input  logic                                  sat_lo_q,
    output logic        [N-2:0]                   body,
    output logic                                  g,
    output logic                                  s
);

    localparam int KW = SW - ES;
    localparam int BW = 2 * N + ES + 2;
    localparam int TW = N + ES;

    localparam logic signed [KW-1:0] K_HI = KW'(N - 2);
    localparam logic signed [KW-1:0] K_LO = KW'(-(N - 2));
    localparam logic [N-2:0] MAXPOS_BODY = (N-1)'(posit_const(N, PC_MAXPOS));
    localparam logic [N-2:0] MINPOS_BODY = (N-1)'(posit_const(N, PC_MINPOS));

    // Dropping the low ES bits of the scale is exactly floor(scale / 2^ES).
    assign k      = scale[SW-1:ES];
    assign e      = (ES > 0) ? scale[((ES > 0) ? ES : 1)-1:0] : '0;
    assign sat_hi = (k > K_HI);
    assign sat_lo = (k < K_LO);

    logic [TW-1:0] tail;

    generate
        if (ES > 0) begin : g_tail_exp
            assign tail = {e_q, frac_q};
        end else begin : g_tail_noexp
            assign tail = frac_q;
        end
    endgenerate

    logic signed [BW-1:0] seed;
    logic signed [BW-1:0] shifted;
    logic        [KW-1:0] sh;

    // Seed "10" (k >= 0) or "01" (k < 0) ahead of the tail; an arithmetic right shift by
    // k or ~k replicates the leading bit, producing the full regime run in one step.
    // NOTE: every variable written in this block gets a value before any branch so no latch is inferred.
    always_comb begin
        sh      = k_q[KW-1] ? ~k_q : k_q;
        seed    = {(k_q[KW-1] ? 2'b01 : 2'b10), tail, {N{1'b0}}};
        shifted = seed >>> sh;
        body    = shifted[BW-1 -: N-1];
        g       = shifted[BW-N];
        s       = (|shifted[BW-N-1:0]) | sticky_q;
        if (sat_hi_q) begin
            body = MAXPOS_BODY;
            g    = 1'b0;
            s    = 1'b0;
        end else if (sat_lo_q) begin
            body = MINPOS_BODY;
            g    = 1'b0;
            s    = 1'b0;
        end
    end

endmodule

// File: rtl/posit_round_pack_pipe.sv
// Three-stage valid/ready posit rounding and packing pipeline with saturation and
// inexact flags; encoding logic lives in posit_regime_enc.
module posit_round_pack_pipe
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int SW = scale_width(N, ES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [SW-1:0] in_scale,
    input  logic        [N-1:0]  in_frac,
    input  logic                 in_sticky,
    input  logic                 in_zero,
    input  logic                 in_nar,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic        [N-1:0]  out_posit,
    output logic                 out_inexact,
    output logic                 out_sat
);

    localparam int KW = SW - ES;
    localparam int EW = (ES > 0) ? ES : 1;
    localparam logic [N-1:0] NAR = N'(posit_const(N, PC_NAR));

    logic v1, v2, v3;
    logic en1, en2, en3;

    assign en3       = out_ready | ~v3;
    assign en2       = en3 | ~v2;
    assign en1       = en2 | ~v1;
    assign in_ready  = en1;
    assign out_valid = v3;

    logic signed [KW-1:0] k_d;
    logic        [EW-1:0] e_d;
    logic                 sat_hi_d, sat_lo_d;

    logic                 s1_sign, s1_sticky, s1_zero, s1_nar, s1_sat_hi, s1_sat_lo;
    logic signed [KW-1:0] s1_k;
    logic        [EW-1:0] s1_e;
    logic        [N-1:0]  s1_frac;
    rnd_mode_e            s1_mode;

    logic        [N-2:0]  body_d;
    logic                 g_d, s_d;

    logic                 s2_sign, s2_g, s2_s, s2_sat, s2_zero, s2_nar;
    logic        [N-2:0]  s2_body;
    rnd_mode_e            s2_mode;

    posit_regime_enc #(
        .N  (N),
        .ES (ES),
        .SW (SW)
    ) u_enc (
        .scale    (in_scale),
        .k        (k_d),
        .e        (e_d),
        .sat_hi   (sat_hi_d),
        .sat_lo   (sat_lo_d),
        .k_q      (s1_k),
        .e_q      (s1_e),
        .frac_q   (s1_frac),
        .sticky_q (s1_sticky),
        .sat_hi_q (s1_sat_hi),
        .sat_lo_q (s1_sat_lo),
        .body     (body_d),
        .g        (g_d),
        .s        (s_d)
    );

    // NOTE: only the valid bits and the visible outputs take reset; payload registers are
    // qualified by their valid bit, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
            if (en3) v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            s1_sign   <= in_sign;
            s1_k      <= k_d;
            s1_e      <= e_d;
            s1_frac   <= in_frac;
            s1_sticky <= in_sticky;
            s1_sat_hi <= sat_hi_d;
            s1_sat_lo <= sat_lo_d;
            s1_nar    <= in_nar;
            s1_zero   <= in_zero & ~in_nar;
            s1_mode   <= rnd_mode_e'(in_mode);
        end
    end

    always_ff @(posedge clk) begin
        if (en2 && v1) begin
            s2_sign <= s1_sign;
            s2_body <= body_d;
            s2_g    <= g_d;
            s2_s    <= s_d;
            s2_sat  <= s1_sat_hi | s1_sat_lo;
            s2_zero <= s1_zero;
            s2_nar  <= s1_nar;
            s2_mode <= s1_mode;
        end
    end

    logic         inc;
    logic         special;
    logic [N-1:0] mag;
    logic [N-1:0] posit_d;

    // The regime always places a one inside the body, so mag is never zero.
    always_comb begin
        special = s2_nar | s2_zero;
        inc     = (s2_mode == RND_RNE) & s2_g & (s2_body[0] | s2_s) & ~(&s2_body);
        mag     = {1'b0, s2_body} + N'(inc);
        posit_d = s2_sign ? -mag : mag;
        if (s2_nar) begin
            posit_d = NAR;
        end else if (s2_zero) begin
            posit_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_posit   <= '0;
            out_inexact <= 1'b0;
            out_sat     <= 1'b0;
        end else if (en3 && v2) begin
            out_posit   <= posit_d;
            out_inexact <= ~special & (s2_sat | s2_g | s2_s);
            out_sat     <= ~special & s2_sat;
        end
    end

endmodule

// File: tb/tb_posit_round_pack_pipe.sv
// Self-checking bench for posit_round_pack_pipe (N=32, ES=2): directed encodings,
// rounding, saturation, specials, backpressure, random traffic and reset mid-flight.
module tb_posit_round_pack_pipe;

    localparam int N  = 32;
    localparam int ES = 2;
    localparam int SW = 9;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic signed [SW-1:0] in_scale;
    logic        [N-1:0]  in_frac;
    logic                 in_sticky;
    logic                 in_zero;
    logic                 in_nar;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic        [N-1:0]  out_posit;
    logic                 out_inexact;
    logic                 out_sat;

    int vectors    = 0;
    int miscompares = 0;

    posit_round_pack_pipe #(
        .N  (N),
        .ES (ES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_scale    (in_scale),
        .in_frac     (in_frac),
        .in_sticky   (in_sticky),
        .in_zero     (in_zero),
        .in_nar      (in_nar),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_posit   (out_posit),
        .out_inexact (out_inexact),
        .out_sat     (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 sign;
        logic signed [SW-1:0] scale;
        logic [31:0]          frac;
        logic                 sticky;
        logic                 zero;
        logic                 nar;
        logic                 mode;
    } beat_t;

    typedef struct packed {
        logic [31:0] posit;
        logic        inexact;
        logic        sat;
    } res_t;

    typedef struct {
        string       name;
        beat_t       b;
        logic [31:0] p;
        logic        inex;
        logic        sat;
    } dvec_t;

    // Reference: write out the posit bit string (regime, exponent, fraction) into a queue,
    // take the first 31 bits as the body and round on the remainder.
    function automatic res_t ref_model(input beat_t b);
        res_t        r;
        bit          q[$];
        int          scale, k, e;
        logic [30:0] body;
        logic        guard, st;
        logic [31:0] mag;
        r.posit = 32'h0; r.inexact = 1'b0; r.sat = 1'b0;
        if (b.nar) begin
            r.posit = 32'h8000_0000;
            return r;
        end
        if (b.zero) return r;
        scale = int'(b.scale);
        k = (scale >= 0) ? scale / 4 : -((3 - scale) / 4);
        e = scale - 4 * k;
        if (k > 30) begin
            mag = 32'h7FFF_FFFF; r.inexact = 1'b1; r.sat = 1'b1;
        end else if (k < -30) begin
            mag = 32'h0000_0001; r.inexact = 1'b1; r.sat = 1'b1;
        end else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            q.push_back(e[1]);
            q.push_back(e[0]);
            for (int i = 31; i >= 0; i--) q.push_back(b.frac[i]);
            body = '0;
            for (int i = 0; i < 31; i++) body = {body[29:0], q[i]};
            guard = q[31];
            st = b.sticky;
            for (int i = 32; i < q.size(); i++) st = st | q[i];
            mag = {1'b0, body};
            if (!b.mode && guard && (body[0] || st) && body != 31'h7FFF_FFFF) mag = mag + 32'd1;
            r.inexact = guard | st;
        end
        r.posit = b.sign ? -mag : mag;
        return r;
    endfunction

    function automatic beat_t mk_beat(input logic sign, input int scale, input logic [31:0] frac,
                                      input logic sticky, input logic zero, input logic nar,
                                      input logic mode);
        beat_t b;
        b.sign = sign; b.scale = SW'(scale); b.frac = frac;
        b.sticky = sticky; b.zero = zero; b.nar = nar; b.mode = mode;
        return b;
    endfunction

    function automatic dvec_t dv(input string name, input beat_t b, input logic [31:0] p,
                                 input logic inex, input logic sat);
        dvec_t d;
        d.name = name; d.b = b; d.p = p; d.inex = inex; d.sat = sat;
        return d;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.sign = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 6) b.scale = SW'(int'($urandom_range(0, 260)) - 130);
        else                          b.scale = SW'($urandom_range(0, 511));
        if ($urandom_range(0, 1) == 1) b.frac = $urandom;
        else                           b.frac = $urandom & 32'h0000_007F;
        b.sticky = ($urandom_range(0, 3) == 0);
        b.mode   = 1'($urandom_range(0, 1));
        b.zero   = ($urandom_range(0, 19) == 0);
        b.nar    = ($urandom_range(0, 19) == 0);
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_sign   = b.sign;
        in_scale  = b.scale;
        in_frac   = b.frac;
        in_sticky = b.sticky;
        in_zero   = b.zero;
        in_nar    = b.nar;
        in_mode   = b.mode;
    endtask

    // One beat through an empty pipe; reports the output and cycles from acceptance edge.
    task automatic xfer(input beat_t b, output logic [31:0] p, output logic inex,
                        output logic sat, output int lat);
        drive(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        p = out_posit; inex = out_inexact; sat = out_sat;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(mk_beat(0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, out_posit, out_inexact, out_sat} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b posit=%h inex=%b sat=%b, expected all 0",
                     out_valid, out_posit, out_inexact, out_sat);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_encode();
        dvec_t t[$];
        logic [31:0] p; logic inex, sat; int lat;
        t.push_back(dv("enc_one",     mk_beat(0, 0, 0, 0, 0, 0, 0), 32'h4000_0000, 0, 0));
        t.push_back(dv("enc_neg_one", mk_beat(1, 0, 0, 0, 0, 0, 0), 32'hC000_0000, 0, 0));
        t.push_back(dv("enc_scale4",  mk_beat(0, 4, 0, 0, 0, 0, 0), 32'h6000_0000, 0, 0));
        foreach (t[i]) begin
            xfer(t[i].b, p, inex, sat, lat);
            vectors++;
            if ({p, inex, sat} !== {t[i].p, t[i].inex, t[i].sat}) begin
                miscompares++;
                $display("FAIL %s: got %h/%b/%b expected %h/%b/%b", t[i].name, p, inex, sat, t[i].p, t[i].inex, t[i].sat);
            end
            vectors++;
            if (lat !== 3) begin
                miscompares++;
                $display("FAIL %s_latency: got %0d expected 3", t[i].name, lat);
            end
        end
    endtask

    task automatic test_rounding();
        dvec_t t[$];
        logic [31:0] p; logic inex, sat; int lat;
        t.push_back(dv("rne_tie_even",  mk_beat(0, 0, 32'h10, 0, 0, 0, 0), 32'h4000_0000, 1, 0));
        t.push_back(dv("rne_tie_odd",   mk_beat(0, 0, 32'h30, 0, 0, 0, 0), 32'h4000_0002, 1, 0));
        t.push_back(dv("rtz_trunc",     mk_beat(0, 0, 32'h30, 0, 0, 0, 1), 32'h4000_0001, 1, 0));
        t.push_back(dv("rne_sticky_up", mk_beat(0, 0, 32'h10, 1, 0, 0, 0), 32'h4000_0001, 1, 0));
        t.push_back(dv("rne_minpos_up", mk_beat(0, -118, 0, 0, 0, 0, 0),    32'h0000_0002, 1, 0));
        foreach (t[i]) begin
            xfer(t[i].b, p, inex, sat, lat);
            vectors++;
            if ({p, inex, sat} !== {t[i].p, t[i].inex, t[i].sat}) begin
                miscompares++;
                $display("FAIL %s: got %h/%b/%b expected %h/%b/%b", t[i].name, p, inex, sat, t[i].p, t[i].inex, t[i].sat);
            end
            vectors++;
            if (lat !== 3) begin
                miscompares++;
                $display("FAIL %s_latency: got %0d expected 3", t[i].name, lat);
            end
        end
    endtask

    task automatic test_saturation();
        dvec_t t[$];
        logic [31:0] p; logic inex, sat; int lat;
        t.push_back(dv("sat_max",         mk_beat(0, 200, 0, 0, 0, 0, 0),  32'h7FFF_FFFF, 1, 1));
        t.push_back(dv("sat_min",         mk_beat(0, -200, 0, 0, 0, 0, 0), 32'h0000_0001, 1, 1));
        t.push_back(dv("sat_min_neg",     mk_beat(1, -200, 0, 0, 0, 0, 0), 32'hFFFF_FFFF, 1, 1));
        t.push_back(dv("edge_maxpos",     mk_beat(0, 120, 0, 0, 0, 0, 0),  32'h7FFF_FFFF, 0, 0));
        t.push_back(dv("edge_maxpos_inx", mk_beat(0, 123, 0, 0, 0, 0, 0),  32'h7FFF_FFFF, 1, 0));
        t.push_back(dv("edge_k31",        mk_beat(0, 124, 0, 0, 0, 0, 0),  32'h7FFF_FFFF, 1, 1));
        t.push_back(dv("edge_minpos",     mk_beat(0, -120, 0, 0, 0, 0, 0), 32'h0000_0001, 0, 0));
        t.push_back(dv("edge_km31",       mk_beat(0, -121, 0, 0, 0, 0, 0), 32'h0000_0001, 1, 1));
        foreach (t[i]) begin
            xfer(t[i].b, p, inex, sat, lat);
            vectors++;
            if ({p, inex, sat} !== {t[i].p, t[i].inex, t[i].sat}) begin
                miscompares++;
                $display("FAIL %s: got %h/%b/%b expected %h/%b/%b", t[i].name, p, inex, sat, t[i].p, t[i].inex, t[i].sat);
            end
        end
    endtask

    task automatic test_specials();
        dvec_t t[$];
        logic [31:0] p; logic inex, sat; int lat;
        t.push_back(dv("nar_wins",  mk_beat(1, 200, 32'hFFFF_FFFF, 1, 1, 1, 0), 32'h8000_0000, 0, 0));
        t.push_back(dv("zero_only", mk_beat(1, -200, 32'h30, 1, 1, 0, 0),        32'h0000_0000, 0, 0));
        foreach (t[i]) begin
            xfer(t[i].b, p, inex, sat, lat);
            vectors++;
            if ({p, inex, sat} !== {t[i].p, t[i].inex, t[i].sat}) begin
                miscompares++;
                $display("FAIL %s: got %h/%b/%b expected %h/%b/%b", t[i].name, p, inex, sat, t[i].p, t[i].inex, t[i].sat);
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t       bt[5];
        res_t        ex[5];
        int          idx = 0, oidx = 0, acc_stall = 0, first_out = -1, last_out = -1;
        bit          saw_low = 1'b0, have_held = 1'b0;
        logic [31:0] held = '0;
        for (int i = 0; i < 5; i++) begin
            bt[i] = rand_beat();
            bt[i].zero = 1'b0; bt[i].nar = 1'b0;
            ex[i] = ref_model(bt[i]);
        end
        for (int cyc = 0; cyc < 30 && oidx < 5; cyc++) begin
            in_valid = (idx < 5);
            if (idx < 5) drive(bt[idx]);
            out_ready = (cyc >= 6);
            @(negedge clk);
            if (cyc < 6) begin
                if (!in_ready) saw_low = 1'b1;
                if (out_valid) begin
                    if (!have_held) begin
                        held = out_posit; have_held = 1'b1;
                    end else begin
                        vectors++;
                        if (out_posit !== held) begin
                            miscompares++;
                            $display("FAIL bp_hold: got %h expected %h", out_posit, held);
                        end
                    end
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if ({out_posit, out_inexact, out_sat} !== ex[oidx]) begin
                    miscompares++;
                    $display("FAIL bp_beat%0d: got %h/%b/%b expected %h/%b/%b", oidx, out_posit,
                             out_inexact, out_sat, ex[oidx].posit, ex[oidx].inexact, ex[oidx].sat);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                oidx++;
            end
            if (in_valid && in_ready) begin
                idx++;
                if (cyc < 6) acc_stall++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (acc_stall !== 3) begin
            miscompares++;
            $display("FAIL bp_accepted_in_stall: got %0d expected 3", acc_stall);
        end
        vectors++;
        if (!saw_low) begin
            miscompares++;
            $display("FAIL bp_in_ready_low: got never-low expected low during stall");
        end
        vectors++;
        if (oidx !== 5 || last_out - first_out !== 4) begin
            miscompares++;
            $display("FAIL bp_drain: got %0d beats over span %0d expected 5 over 4", oidx, last_out - first_out);
        end
    endtask

    task automatic test_random();
        res_t        exp_q[$];
        res_t        e;
        bit          prev_stall = 1'b0;
        logic [33:0] prev = '0;
        beat_t       b;
        for (int cyc = 0; cyc < 800; cyc++) begin
            b = rand_beat();
            drive(b);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (prev_stall) begin
                vectors++;
                if (!out_valid || {out_posit, out_inexact, out_sat} !== prev) begin
                    miscompares++;
                    $display("FAIL rnd_hold: got %b/%h expected held %h", out_valid, {out_posit, out_inexact, out_sat}, prev);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_posit, out_inexact, out_sat};
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_extra_beat: got %h expected no beat", out_posit);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_posit, out_inexact, out_sat} !== e) begin
                        miscompares++;
                        $display("FAIL rnd_beat: got %h/%b/%b expected %h/%b/%b", out_posit, out_inexact,
                                 out_sat, e.posit, e.inexact, e.sat);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_model(b));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_extra_beat: got %h expected no beat", out_posit);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_posit, out_inexact, out_sat} !== e) begin
                        miscompares++;
                        $display("FAIL rnd_drain: got %h/%b/%b expected %h/%b/%b", out_posit, out_inexact,
                                 out_sat, e.posit, e.inexact, e.sat);
                    end
                end
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_lost_beats: got %0d missing expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        beat_t       b;
        res_t        r;
        logic [31:0] p; logic inex, sat; int lat;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(mk_beat(0, i * 4, 32'h1234_5678, 0, 0, 0, 0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_prefill: got out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_posit !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_flush: got valid=%b ready=%b posit=%h expected 0 1 00000000", out_valid, in_ready, out_posit);
        end
        @(posedge clk); #1;
        b = mk_beat(1, 4, 32'h8000_0000, 0, 0, 0, 0);
        r = ref_model(b);
        xfer(b, p, inex, sat, lat);
        vectors++;
        if ({p, inex, sat} !== r) begin
            miscompares++;
            $display("FAIL rst_next_beat: got %h/%b/%b expected %h/%b/%b", p, inex, sat, r.posit, r.inexact, r.sat);
        end
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL rst_next_latency: got %0d expected 3", lat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encode();
        test_rounding();
        test_saturation();
        test_specials();
        test_backpressure();
        test_random();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/posit_round_pack_pipe.md
# posit_round_pack_pipe

Pipelined, parametrised posit rounding/packing stage that turns an unpacked result into an N-bit posit. The unpacked result is sign, total scale, MSB-aligned fraction, sticky, zero and NaR. It sits at the tail of the posit add/mul datapaths and replaces per-unit combinational packing logic. Over a plain packer it adds a valid/ready pipeline, a selectable rounding mode, explicit saturation to maxpos/minpos, and inexact/saturate flags.

## Interface
Parameters:
- N, 32, posit width (8..64)
- ES, 2, exponent field width (0..4)
- SW, $clog2(N)+ES+2, signed scale width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts input this cycle
- in_sign  in  1  result sign
- in_scale  in  SW  signed total exponent (k·2^ES + e)
- in_frac  in  N  fraction bits after the hidden bit, MSB-aligned
- in_sticky  in  1  OR of fraction bits already discarded upstream
- in_zero  in  1  result is zero
- in_nar  in  1  result is NaR (wins over in_zero)
- in_mode  in  1  0 = round-nearest-even, 1 = round-toward-zero
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_posit  out  N  packed posit
- out_inexact  out  1  a nonzero bit was discarded
- out_sat  out  1  result was clamped to ±maxpos/±minpos

## Operation
- k = in_scale >>> ES (floor); e = in_scale[ES-1:0].
- Regime:
  - k ≥ 0: k+1 ones then a zero.
  - k < 0: −k zeros then a one.
- Saturation:
  - k > N−2 → body 0x7F..F, out_sat = 1.
  - k < −(N−2) → body 0x0..01, out_sat = 1.
  - Saturated results take no rounding increment.
- Body assembly: concatenate {regime, e, frac} into a 2N+ES+2 buffer. The top N−1 bits form the body, L is the body LSB, G is the next bit, and S is the OR of all lower bits and in_sticky.
- Rounding:
  - RNE: inc = G & (L | S).
  - RTZ: inc = 0.
  - If the body is all ones, inc is forced to 0; a posit never rounds to NaR.
  - A nonzero body never rounds to 0.
  - out_inexact = G | S, or 1 on saturation with discarded magnitude.
- Sign: out_posit = sign ? −{0, body+inc} : {0, body+inc}, in N-bit two's complement.
- Specials:
  - in_nar → 1 followed by N−1 zeros.
  - in_zero → all zeros.
  - Both specials force out_inexact = out_sat = 0.
- Three stages:
  - S1 registers k, e, saturation decode and the special flags.
  - S2 registers body, L/G/S and mode.
  - S3 registers the final posit and flags.

## Timing
- Latency 3 cycles from input handshake to out_valid, at one beat per cycle throughput.
- Stage enables:
  - en3 = out_ready | ~v3
  - en2 = en3 | ~v2
  - en1 = en2 | ~v1
  - in_ready = en1, combinational from out_ready and the valid bits.
- A beat transfers when valid & ready. out_posit and flags hold stable while out_valid & ~out_ready.
- in_ready stays high with a full pipe as long as out_ready = 1.
- Reset (rst_n = 0 at the clock edge):
  - v1/v2/v3 = 0, out_valid = 0, out_posit = 0, out_inexact = 0, out_sat = 0.
  - In-flight beats are dropped, not flushed.
  - in_ready = 1 in the first cycle after reset.
- Order is preserved; no beat is duplicated or lost under any out_ready pattern.

## Structure
- posit_pkg holds:
  - the rounding-mode enum (RND_RNE = 0, RND_RTZ = 1)
  - the function computing maxpos/minpos/NaR constants from N
  - the SW width function
- A combinational sub-module `posit_regime_enc` holds k/e decode, saturation detect and body/G/S assembly (S1–S2 logic).
- The top holds the pipeline registers, handshake, increment/negate and specials.

## Test plan
All scenarios use N=32, ES=2, in_mode=0 and out_ready=1 unless stated otherwise.
- scale 0, frac 0 → 0x40000000; sign=1 → 0xC0000000; scale 4 → 0x60000000; flags 0, each 3 cycles after acceptance.
- scale 0, frac 0x00000010, sticky 0 → 0x40000000, inexact=1 (tie, even). frac 0x00000030 → 0x40000002 (tie, odd, rounds up). frac 0x00000030 with mode=1 → 0x40000001.
- scale 200 → 0x7FFFFFFF, sat=1. scale −200 → 0x00000001, sat=1. scale −200 with sign=1 → 0xFFFFFFFF.
- in_nar=1 with in_zero=1 → 0x80000000. in_zero alone → 0x00000000. Flags 0 in both cases.
- Backpressure:
  - Stimulus: out_ready held 0 for 6 cycles while 5 beats are offered back-to-back.
  - During the stall: exactly 3 beats are accepted, in_ready falls low, and out_posit stays stable.
  - After release: all 5 beats emerge in order with no gaps.
- rst_n pulsed low for one cycle with 3 beats in flight → out_valid = 0 the next cycle. The next accepted beat appears exactly 3 cycles later with the correct value.
